stream_downsizer_fifo: RTL and testbench

//   Buffered width-down converter for the stream_in path. Accepts full DATA_WIDTH

---
 rtl/stream_downsizer_fifo.sv | 146 ++++++++++++++
 tb/tb_stream_downsizer_fifo.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_downsizer_fifo.sv
// -----------------------------------------------------------------------------
// stream_downsizer_fifo
//
// Purpose:
//   Buffered width-down converter. Full DATA_WIDTH words enter a DEPTH-entry
//   FIFO over a valid/ready stream. Each stored word leaves as
//   RATIO = DATA_WIDTH/OUT_WIDTH narrow beats, least-significant slice first.
//   The packet-end flag of a word is carried only on that word's final beat.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
//   The source holds valid/data/last stable until that edge. Neither ready
//   depends combinationally on the opposite side's valid, and there is no
//   combinational path from the input side to the output side.
//
// Ports:
//   clk        in   1                 single rising-edge clock
//   reset      in   1                 asynchronous, active-low reset
//   in_valid   in   1                 input word valid
//   in_ready   out  1                 FIFO can accept a word this cycle
//   in_data    in   DATA_WIDTH        input word
//   in_last    in   1                 word is the final word of a packet
//   out_valid  out  1                 output beat valid
//   out_ready  in   1                 downstream accepts the beat
//   out_data   out  OUT_WIDTH         current slice of the head word
//   out_last   out  1                 final beat of a packet
//   level      out  $clog2(DEPTH+1)   words held, including the partial head
// -----------------------------------------------------------------------------
module stream_downsizer_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int OUT_WIDTH  = 16,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_WIDTH-1:0]         out_data,
    output logic                         out_last,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int RATIO = DATA_WIDTH / OUT_WIDTH;
    localparam int PW    = $clog2(DEPTH);
    localparam int LW    = $clog2(DEPTH + 1);
    // A one-beat word still needs a one-bit counter; it simply never leaves 0.
    localparam int SW    = (RATIO > 1) ? $clog2(RATIO) : 1;

    // Word storage; the last flag lives beside its word.
    logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
    logic [DEPTH-1:0]      last_mem_q;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q,  level_d;
    logic [SW-1:0] slice_q,  slice_d;

    logic                  push;
    logic                  beat;
    logic                  last_beat;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  head_last;
    logic [OUT_WIDTH-1:0]  head_slice;

    // Ready comes from the registered level only: a full FIFO refuses a word
    // even in a cycle where the head is being freed.
    assign in_ready  = reset && (level_q != LW'(DEPTH));
    assign out_valid = reset && (level_q != '0);
    assign level     = level_q;

    assign push      = in_valid && in_ready;
    assign beat      = out_valid && out_ready;
    assign last_beat = (slice_q == SW'(RATIO - 1));
    assign pop       = beat && last_beat;

    assign head_data = data_mem_q[rd_ptr_q];
    assign head_last = last_mem_q[rd_ptr_q];

    // Slice mux with constant part-select bases.
    always_comb begin
        head_slice = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (slice_q == SW'(i)) begin
                head_slice = head_data[i*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    // Outputs read as zero when nothing valid is held (including in reset),
    // so stale memory contents never leak onto the bus.
    assign out_data = out_valid ? head_slice : '0;
    assign out_last = out_valid && head_last && last_beat;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        slice_d  = slice_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end

        if (beat) begin
            if (last_beat) begin
                slice_d  = '0;
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                slice_d  = slice_q + SW'(1);
            end
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            slice_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            slice_q  <= slice_d;
        end
    end

    // Storage needs no reset: nothing is read until level says it was written.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem_q[wr_ptr_q] <= in_data;
            last_mem_q[wr_ptr_q] <= in_last;
        end
    end

endmodule

// File: tb/tb_stream_downsizer_fifo.sv
// -----------------------------------------------------------------------------
// tb_stream_downsizer_fifo
//
// Bench for stream_downsizer_fifo. The main instance (64 -> 16, depth 4) is
// followed every cycle by a word-queue model. A second instance built with
// OUT_WIDTH = 64 covers the one-beat-per-word build with directed checks.
// -----------------------------------------------------------------------------
module tb_stream_downsizer_fifo;

    localparam int DW    = 64;
    localparam int OW    = 16;
    localparam int DEPTH = 4;
    localparam int RATIO = DW / OW;
    localparam int LW    = $clog2(DEPTH + 1);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- main DUT signals ----------------
    logic          in_valid, in_ready, in_last;
    logic [DW-1:0] in_data;
    logic          out_valid, out_ready, out_last;
    logic [OW-1:0] out_data;
    logic [LW-1:0] level;

    // ---------------- one-beat DUT signals ----------------
    logic          b_in_valid, b_in_ready, b_in_last;
    logic [DW-1:0] b_in_data;
    logic          b_out_valid, b_out_ready, b_out_last;
    logic [DW-1:0] b_out_data;
    logic [LW-1:0] b_level;

    stream_downsizer_fifo #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .reset(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .level(level)
    );

    stream_downsizer_fifo #(.DATA_WIDTH(DW), .OUT_WIDTH(DW), .DEPTH(DEPTH)) u_dut_r1 (
        .clk(clk), .reset(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last),
        .level(b_level)
    );

    // ---------------- bookkeeping ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // exp_q holds whole words {last, data}; m_slice is how many beats of the
    // head word have already left.
    logic [DW:0]   exp_q[$];
    int            m_slice = 0;
    logic [OW:0]   obs_q[$];       // accepted beats {last, data} as seen on the bus
    logic          m_ready, m_valid;
    logic [DW:0]   m_head;
    logic [OW-1:0] m_data;
    logic          m_last;

    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_slice = 0;
        end else begin
            m_ready = (exp_q.size() != DEPTH);
            m_valid = (exp_q.size() != 0);
            if (m_valid && out_ready) begin
                if (m_slice == RATIO - 1) begin
                    void'(exp_q.pop_front());
                    m_slice = 0;
                end else begin
                    m_slice++;
                end
            end
            if (in_valid && m_ready) exp_q.push_back({in_last, in_data});
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_out_data",  out_data,  0);
            check("rst_out_last",  out_last,  0);
            check("rst_in_ready",  in_ready,  0);
            check("rst_level",     level,     0);
            check("rst_r1_valid",  b_out_valid, 0);
            check("rst_r1_ready",  b_in_ready,  0);
        end else begin
            check("level",     level,     exp_q.size());
            check("in_ready",  in_ready,  exp_q.size() != DEPTH);
            check("out_valid", out_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                m_head = exp_q[0];
                m_data = OW'(m_head[DW-1:0] >> (m_slice * OW));
                m_last = m_head[DW] && (m_slice == RATIO - 1);
                check("out_data", out_data, m_data);
                check("out_last", out_last, m_last);
            end
            if (out_valid && out_ready) obs_q.push_back({out_last, out_data});
        end
    end

    // ---------------- out_ready driver ----------------
    logic rnd_mode  = 1'b0;
    logic or_manual = 1'b0;
    always @(posedge clk) begin
        #2;
        out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : or_manual;
    end

    // ---------------- driver tasks ----------------
    // Present a word until accepted (bounded); returns 1 time unit after the
    // accepting edge.
    task automatic push_word(input logic [DW-1:0] d, input logic l);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int c = 0; c < 300 && !acc; c++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) check("push_timeout", acc, 1);
    endtask

    task automatic drain(input string nm);
        logic done;
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            done = (level == 0);
        end
        check(nm, done, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        checks++;
        failures++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- main stimulus ----------------
    logic [DW-1:0] w6 [5];
    logic          l6 [5];

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0; b_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        // Test 1: single word, continuous ready
        or_manual = 1'b1;
        obs_q.delete();
        push_word(64'h4444_3333_2222_1111, 1'b1);
        drain("t1_drain");
        check("t1_beats", obs_q.size(), 4);
        if (obs_q.size() == 4) begin
            check("t1_b0", obs_q[0], {1'b0, 16'h1111});
            check("t1_b1", obs_q[1], {1'b0, 16'h2222});
            check("t1_b2", obs_q[2], {1'b0, 16'h3333});
            check("t1_b3", obs_q[3], {1'b1, 16'h4444});
        end

        // Test 2: fill with downstream stalled, fifth word waits
        or_manual = 1'b0;
        idle(1);
        for (int i = 0; i < 4; i++) push_word(64'hA000_0000_0000_0000 | 64'(i), 1'(i == 3));
        in_valid = 1'b1;
        in_data  = 64'hA000_0000_0000_0004;
        in_last  = 1'b1;
        @(negedge clk);
        check("t2_level_full", level, 4);
        check("t2_ready_full", in_ready, 0);
        @(posedge clk);
        #1;
        or_manual = 1'b1;
        push_word(64'hA000_0000_0000_0004, 1'b1);
        drain("t2_drain");

        // Test 3: stall mid-word with out_ready 1,0,0,1
        or_manual = 1'b0;
        obs_q.delete();
        push_word(64'hDDDD_CCCC_BBBB_AAAA, 1'b1);
        or_manual = 1'b1; idle(1);
        or_manual = 1'b0; idle(1);
        or_manual = 1'b0; idle(1);
        or_manual = 1'b1;
        drain("t3_drain");
        check("t3_beats", obs_q.size(), 4);
        if (obs_q.size() == 4) begin
            check("t3_b1", obs_q[1], {1'b0, 16'hBBBB});
            check("t3_b3", obs_q[3], {1'b1, 16'hDDDD});
        end

        // Test 4: 20 random words, random valid gaps and random ready
        obs_q.delete();
        rnd_mode = 1'b1;
        for (int i = 0; i < 20; i++) begin
            idle($urandom_range(0, 2));
            push_word({$urandom, $urandom}, 1'($urandom_range(0, 1)));
        end
        drain("t4_drain");
        rnd_mode = 1'b0;
        check("t4_beat_count", obs_q.size(), 20 * RATIO);

        // Test 5: reset after two of four beats
        or_manual = 1'b1;
        idle(1);
        obs_q.delete();
        push_word(64'h9999_8888_7777_6666, 1'b1);
        for (int c = 0; c < 20 && obs_q.size() < 2; c++) idle(1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_valid", out_valid, 0);
        check("t5_async_data",  out_data,  0);
        check("t5_async_last",  out_last,  0);
        check("t5_async_ready", in_ready,  0);
        check("t5_async_level", level,     0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("t5_level_after", level, 0);
        @(posedge clk);
        #1;
        obs_q.delete();
        push_word(64'h8888_7777_6666_5555, 1'b1);
        drain("t5_drain");
        check("t5_beats", obs_q.size(), 4);
        if (obs_q.size() == 4) begin
            check("t5_first", obs_q[0], {1'b0, 16'h5555});
            check("t5_final", obs_q[3], {1'b1, 16'h8888});
        end

        // Test 6: one-beat build, fill/stall then drain
        for (int i = 0; i < 5; i++) begin
            w6[i] = 64'h0123_4567_89AB_CDEF ^ (64'(i) << 8);
            l6[i] = (i % 2 == 1);
        end
        b_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b_in_valid = 1'b1;
            b_in_data  = w6[i];
            b_in_last  = l6[i];
            @(negedge clk);
            check("r1_fill_ready", b_in_ready, 1);
            @(posedge clk);
            #1;
        end
        b_in_data = w6[4];
        b_in_last = l6[4];
        @(negedge clk);
        check("r1_level_full", b_level, 4);
        check("r1_ready_full", b_in_ready, 0);
        check("r1_hold_data",  b_out_data, w6[0]);
        @(posedge clk);
        #1;
        b_out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("r1_valid", b_out_valid, 1);
            check("r1_data",  b_out_data,  w6[k]);
            check("r1_last",  b_out_last,  l6[k]);
            if (k == 0) check("r1_ready_k0", b_in_ready, 0);
            if (k == 1) check("r1_ready_k1", b_in_ready, 1);
            @(posedge clk);
            #1;
            if (k == 1) b_in_valid = 1'b0;
        end
        @(negedge clk);
        check("r1_level_empty", b_level, 0);
        check("r1_valid_empty", b_out_valid, 0);
        b_out_ready = 1'b0;

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
